// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - pattern modes and PWM width shared by the LED pattern engine
package led_pkg;

  typedef enum logic [1:0] {
    SHIFT_L  = 2'd0,
    SHIFT_R  = 2'd1,
    PINGPONG = 2'd2,
    BLINK    = 2'd3
  } led_mode_t;

  localparam int PWM_W = 8;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - programmable step divider producing one tick per div_q enabled cycles
module led_tick_gen #(
  parameter int          DIV_W       = 24,
  parameter int unsigned DEFAULT_DIV = 10_000_000
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  // A zero period behaves as one, so the counter never leaves 0 and every cycle ticks.
  assign last = (div_q == '0) ? '0 : div_q - DIV_W'(1);

  // A load restarts the period, so it suppresses any tick falling on the same cycle.
  assign tick = en && !load && (cnt == last);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_W'(DEFAULT_DIV);
      cnt   <= '0;
    end else if (load) begin
      div_q <= div;
      cnt   <= '0;
    end else if (en) begin
      cnt <= (cnt == last) ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - LED pattern generator top; LED_PWM_EN adds a brightness port and PWM output stage
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int          N_LED       = 4,
  parameter int          DIV_W       = 24,
  parameter int unsigned DEFAULT_DIV = 10_000_000
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0] bright,
`endif
  output logic [N_LED-1:0] led,
  output logic             led_step
);

  localparam logic [N_LED-1:0] ONE_LO = N_LED'(1);
  localparam logic [N_LED-1:0] ONE_HI = ONE_LO << (N_LED - 1);

  led_mode_t        mode_q;
  logic [N_LED-1:0] pat;
  logic [N_LED-1:0] nxt;
  logic             dir_up;
  logic             nxt_dir;
  logic             tick;

  led_tick_gen #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_tick (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .en      (en),
    .load    (cfg_valid),
    .div     (div),
    .tick    (tick)
  );

  function automatic logic [N_LED-1:0] start_pat(input led_mode_t m);
    case (m)
      SHIFT_R: start_pat = ONE_HI;
      BLINK:   start_pat = '0;
      default: start_pat = ONE_LO;
    endcase
  endfunction

  // With N_LED=1 both rotates collapse to the identity and ping-pong is held.
  always_comb begin
    nxt     = pat;
    nxt_dir = dir_up;
    case (mode_q)
      SHIFT_L: nxt = (pat << 1) | (pat >> (N_LED - 1));
      SHIFT_R: nxt = (pat >> 1) | (pat << (N_LED - 1));
      PINGPONG: begin
        if (N_LED > 1) begin
          if (dir_up) begin
            if (pat[N_LED-1]) begin
              nxt     = pat >> 1;
              nxt_dir = 1'b0;
            end else begin
              nxt = pat << 1;
            end
          end else begin
            if (pat[0]) begin
              nxt     = pat << 1;
              nxt_dir = 1'b1;
            end else begin
              nxt = pat >> 1;
            end
          end
        end
      end
      BLINK:   nxt = ~pat;
      default: nxt = pat;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= SHIFT_L;
      pat      <= ONE_LO;
      dir_up   <= 1'b1;
      led_step <= 1'b0;
    end else begin
      led_step <= 1'b0;
      if (cfg_valid) begin
        mode_q <= led_mode_t'(mode);
        pat    <= start_pat(led_mode_t'(mode));
        dir_up <= 1'b1;
      end else if (tick) begin
        pat      <= nxt;
        dir_up   <= nxt_dir;
        led_step <= 1'b1;
      end
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      led     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      led     <= pat & {N_LED{pwm_cnt < bright}};
    end
  end
`else
  assign led = pat;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - randomized scoreboard bench for led_pattern_engine against a position-based reference model
module tb_led_pattern_engine;

  localparam int N       = 4;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 7;

  logic             sys_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [DIV_W-1:0] div = '0;
  logic [N-1:0]     led;
  logic             led_step;

  led_pattern_engine #(
    .N_LED       (N),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .mode      (mode),
    .div       (div),
    .led       (led),
    .led_step  (led_step)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int           cyc;
    logic [N-1:0] led;
    logic         step;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  logic [N-1:0] prev_led = N'(1);

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Reference model: LED position as an index, ping-pong as a phase around a 2N-2 cycle.
  int m_mode, m_period, m_el, m_pos;
  bit m_blink;

  function automatic logic [N-1:0] model_led();
    int idx;
    logic [N-1:0] one;
    one = N'(1);
    case (m_mode)
      2: begin
        idx = (m_pos < N) ? m_pos : 2 * N - 2 - m_pos;
        return one << idx;
      end
      3: return m_blink ? {N{1'b1}} : {N{1'b0}};
      default: return one << m_pos;
    endcase
  endfunction

  task automatic model_advance();
    case (m_mode)
      0: m_pos = (m_pos + 1) % N;
      1: m_pos = (m_pos + N - 1) % N;
      2: m_pos = (m_pos + 1) % (2 * N - 2);
      default: m_blink = !m_blink;
    endcase
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_period = DEF_DIV;
    m_el     = 0;
    m_pos    = 0;
    m_blink  = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit c, input int md, input int dv, input bit e);
    @(negedge sys_clk);
    cfg_valid = c;
    mode      = 2'(md);
    div       = DIV_W'(dv);
    en        = e;
    if (c) begin
      m_mode   = md;
      m_period = (dv == 0) ? 1 : dv;
      m_el     = 0;
      m_pos    = (md == 1) ? N - 1 : 0;
      m_blink  = 0;
      sb.push_back('{cyc + 1, model_led(), 1'b0});
    end else if (e) begin
      if (m_el == m_period - 1) begin
        m_el = 0;
        model_advance();
        sb.push_back('{cyc + 1, model_led(), 1'b1});
      end else begin
        m_el++;
      end
    end
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) drive(0, $urandom_range(0, 3), $urandom_range(0, 255), e);
  endtask

  task automatic do_reset();
    @(posedge sys_clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_led_async", led, N'(1));
    check("rst_step_async", led_step, 0);
    @(posedge sys_clk);
    #3;
    check("rst_led_hold", led, N'(1));
    rst_n = 1'b1;
    model_reset();
    prev_led = N'(1);
  endtask

  // Monitor: every cycle either a scheduled update (step or reconfiguration) or a held output.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (rst_n) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          e = sb.pop_front();
          check("led_update", led, e.led);
          check("led_step_update", led_step, e.step);
        end else begin
          check("led_step_idle", led_step, 0);
          check("led_hold", led, prev_led);
        end
        prev_led = led;
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge sys_clk);
    #3;
    check("reset_led", led, N'(1));
    check("reset_step", led_step, 0);
    rst_n = 1'b1;

    run(16, 1);                       // default period after reset
    drive(1, 0, 3, 1); run(15, 1);    // SHIFT_L div 3
    drive(1, 2, 1, 1); run(8, 1);     // PINGPONG div 1
    drive(1, 3, 2, 1); run(3, 1); run(5, 0); run(6, 1);   // BLINK with en dropped
    drive(1, 0, 3, 1);                // reconfigure exactly on a tick
    for (int i = 0; i < 8 && m_el != m_period - 1; i++) run(1, 1);
    drive(1, 1, 3, 1); run(8, 1);
    drive(1, 0, 0, 1); run(5, 1);     // div 0 steps every cycle
    drive(1, 2, 1, 1); run(5, 1);     // ping-pong now moving down
    do_reset();
    run(10, 1);

    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 3), $urandom_range(0, 4),
            $urandom_range(0, 9) != 0);
    end

    run(3, 0);
    @(posedge sys_clk);
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
